gshare_bht: RTL
===============

Name: gshare_bht

Overview:
- Parametrised gshare branch history table: global history register (GHR) XORed with PC index bits selects an N-bit saturating counter.
- Sits in the fetch stage. It provides a taken/not-taken prediction plus the GHR snapshot used to form it.
- Accepts resolution updates from execute and restores the GHR on a mispredict.
- Adds configurable counter width, speculative history and a self-initialising table after synchronous reset.

Parameters:
- IDX_WIDTH, 10, table index width; table holds 2**IDX_WIDTH counters.
- GHR_WIDTH, 8, global history length; legal range 1..IDX_WIDTH.
- CTR_WIDTH, 2, saturating counter width; legal range 1..4.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- read  in  1  fetch lookup request
- r_idx  in  IDX_WIDTH  PC index bits of fetched branch
- prediction  out  1  predicted direction, 1 = taken
- pred_ghr  out  GHR_WIDTH  GHR value used for this lookup, carried down the pipe
- load  in  1  branch resolution update valid
- w_idx  in  IDX_WIDTH  PC index bits of resolved branch
- w_ghr  in  GHR_WIDTH  pred_ghr captured at that branch's lookup
- taken  in  1  actual resolved direction
- mispredict  in  1  resolved direction differed from prediction; qualified by load
- ready  out  1  table initialised, lookups/updates accepted

Behaviour:
- Index forming:
  - Lookup index = r_idx XOR zero-extended ghr (GHR in low bits).
  - Update index = w_idx XOR zero-extended w_ghr.
- Counters: CTR_WIDTH bits, unsigned.
  - Predict taken iff MSB = 1.
  - Update: taken increments and saturates at all-ones; not-taken decrements and saturates at 0.
- Init FSM, states INIT and READY:
  - rst forces INIT, init pointer = 0, ghr = 0, ready = 0.
  - In INIT, write counter[ptr] = weakly taken (MSB 1, others 0, i.e. 2**(CTR_WIDTH-1)) and increment ptr each cycle.
  - After writing index 2**IDX_WIDTH-1, go to READY; ready = 1 from the next cycle.
  - Init takes exactly 2**IDX_WIDTH cycles after rst deasserts.
  - rst asserted in any state, including mid-INIT, restarts INIT from ptr 0.
- Outputs while not ready:
  - prediction = 0, pred_ghr = 0.
  - read and load ignored: no counter or GHR change.
- Lookup (READY):
  - prediction and pred_ghr are combinational from current table and GHR, same cycle as read.
  - With read = 0: prediction = 0, pred_ghr = current ghr.
- Speculative history: read && ready && no mispredict load that cycle → ghr <= {ghr[GHR_WIDTH-2:0], prediction} at posedge. For GHR_WIDTH = 1, ghr <= prediction.
- Update (READY, load = 1):
  - Counter at update index updated at posedge.
  - If mispredict: ghr <= {w_ghr[GHR_WIDTH-2:0], taken}. This overrides the speculative shift from a same-cycle read.
  - load without mispredict leaves ghr to the speculative rule only.
- Simultaneous read and load, same lookup and update index: prediction uses the post-update counter MSB (write-through bypass). Different indices are independent.
- mispredict with load = 0: ignored.
- No stalls or backpressure. Update latency 1 cycle: a lookup in the cycle after load sees the new counter.

Test Plan:
- Reset/init, IDX_WIDTH = 4: pulse rst 1 cycle → ready low exactly 16 cycles, then high; every index reads prediction = 1 (counter 2'b10). Reassert rst at init cycle 5 → ready low a further 16 cycles.
- Saturation, CTR_WIDTH = 2:
  - Three not-taken loads to the same index (w_ghr = 0): counter 10→01→00→00, prediction 0 after the first.
  - Four taken loads return it to 11, prediction 1.
- Speculative GHR, GHR_WIDTH = 4: three reads with predictions 1,1,0 from ghr = 0 → pred_ghr sequence 0000, 0001, 0011, next 0110.
- Recovery: after the reads above, load with mispredict = 1, w_ghr = 4'b0001, taken = 0 and a simultaneous read → next-cycle pred_ghr = 4'b0010, not the speculative value.
- Bypass: counter at index 5 = 01; same cycle read (lookup index 5) and load taken (update index 5) → prediction = 1 that cycle; counter = 10 afterwards.
- Index hashing: r_idx = 10'h0F3 with ghr = 8'h0F → counter 10'h0FC accessed. Verify by preloading that entry to 00 via loads and observing prediction = 0 while the neighbour 10'h0F3 (lookup with ghr = 0) still predicts 1.

Source files
------------

// File: rtl/gshare_bht.sv
// gshare_bht: gshare predictor, GHR xor PC index selects a saturating counter; table self-initialises after reset
module gshare_bht #(
    parameter int IDX_WIDTH = 10,
    parameter int GHR_WIDTH = 8,
    parameter int CTR_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 read,
    input  logic [IDX_WIDTH-1:0] r_idx,
    output logic                 prediction,
    output logic [GHR_WIDTH-1:0] pred_ghr,
    input  logic                 load,
    input  logic [IDX_WIDTH-1:0] w_idx,
    input  logic [GHR_WIDTH-1:0] w_ghr,
    input  logic                 taken,
    input  logic                 mispredict,
    output logic                 ready
);
    typedef enum logic {INIT, READY} state_t;
    localparam logic [CTR_WIDTH-1:0] WEAK = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    state_t state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [CTR_WIDTH-1:0] table_q [2**IDX_WIDTH];
    logic [IDX_WIDTH-1:0] r_hash, w_hash;
    logic [CTR_WIDTH-1:0] w_ctr, w_new, r_ctr;
    logic [GHR_WIDTH:0]   spec_hist, fix_hist;
    logic                 upd;
    assign ready = (state_q == READY);
    always_comb begin
        r_hash     = r_idx ^ IDX_WIDTH'(ghr_q);
        w_hash     = w_idx ^ IDX_WIDTH'(w_ghr);
        w_ctr      = table_q[w_hash];
        w_new      = taken ? (&w_ctr ? w_ctr : w_ctr + CTR_WIDTH'(1))
                           : (|w_ctr ? w_ctr - CTR_WIDTH'(1) : w_ctr);
        upd        = ready && load;
        // same-cycle update of the looked-up entry is forwarded to the prediction
        r_ctr      = (upd && w_hash == r_hash) ? w_new : table_q[r_hash];
        prediction = ready && read && r_ctr[CTR_WIDTH-1];
        pred_ghr   = ready ? ghr_q : '0;
        spec_hist  = {ghr_q, prediction};
        fix_hist   = {w_ghr, taken};
        ghr_d      = !ready ? ghr_q
                   : (load && mispredict) ? fix_hist[GHR_WIDTH-1:0]
                   : read ? spec_hist[GHR_WIDTH-1:0] : ghr_q;
        ptr_d      = ready ? ptr_q : ptr_q + IDX_WIDTH'(1);
        state_d    = (state_q == INIT && &ptr_q) ? READY : state_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ghr_q   <= ghr_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready)
                table_q[ptr_q] <= WEAK;
            else if (load)
                table_q[w_hash] <= w_new;
        end
    end
endmodule
